pe_arr_tile: RTL and testbench

Parametrised, output-stationary systolic MAC tile, the next generation of `PE_ARR`. It adds configurable operand and accumulator widths, internal input skewing and a valid/ready handshake on input and output. It also adds a tile-length (K) boundary marked by `in_last` and a row-serial drain of results. It sits between the weight/activation stream buffers and the result write-back path.

---
 rtl/pe_arr_pkg.sv | 40 ++++
 rtl/pe_cell.sv | 72 +++++++
 rtl/pe_arr_tile.sv | 222 ++++++++++++++++++++++
 tb/tb_pe_arr_tile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_arr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_arr_pkg : shared FSM state, default widths and saturating add for the   |
// |              pe_arr_tile systolic MAC tile (saturation under PE_ARR_SAT_EN) |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package pe_arr_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } pe_state_t;

  // Adds two values already inside a w-bit signed range and clamps the sum to it.
  function automatic longint sat_add(input longint a, input longint b, input int w,
                                     output logic clamp);
    longint s;
    longint hi;
    longint lo;
    hi    = (longint'(1) <<< (w - 1)) - 1;
    lo    = -hi - 1;
    s     = a + b;
    clamp = 1'b0;
    if (s > hi) begin
      s     = hi;
      clamp = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      clamp = 1'b1;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_cell : one output-stationary MAC with a/w forwarding registers and an   |
// |           accumulator clear; saturating accumulate under PE_ARR_SAT_EN     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pe_cell
  import pe_arr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_w,
  output logic signed [DATA_W-1:0] o_a,
  output logic signed [DATA_W-1:0] o_w,
  output logic signed [ACC_W-1:0]  o_acc
`ifdef PE_ARR_SAT_EN
  ,
  output logic                     o_ovf
`endif
);

  logic signed [DATA_W-1:0]   r_a;
  logic signed [DATA_W-1:0]   r_w;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_nxt;

  assign w_prod     = i_a * i_w;
  assign w_prod_ext = ACC_W'(w_prod);

`ifdef PE_ARR_SAT_EN
  logic w_clamp;

  always_comb begin
    w_clamp   = 1'b0;
    w_acc_nxt = ACC_W'(sat_add(longint'(r_acc), longint'(w_prod_ext), ACC_W, w_clamp));
  end

  assign o_ovf = i_en & w_clamp;
`else
  assign w_acc_nxt = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a   <= '0;
      r_w   <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_a   <= '0;
      r_w   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_w   <= i_w;
      r_acc <= w_acc_nxt;
    end
  end

  assign o_a   = r_a;
  assign o_w   = r_w;
  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pe_arr_tile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_arr_tile : output-stationary ROWSxCOLS systolic MAC tile with input     |
// |               skew, K-boundary flush and row-serial drain.                 |
// |               Define PE_ARR_SAT_EN for saturating accumulation + ovf flag. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pe_arr_tile
  import pe_arr_pkg::*;
#(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ACC_W  = ACC_W_DEF,
  localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [COLS*DATA_W-1:0]  in_w,
  input  logic [ROWS*DATA_W-1:0]  in_a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_row,
  output logic [IDX_W-1:0]        out_row_idx,
  output logic                    out_last,
  output logic                    busy
`ifdef PE_ARR_SAT_EN
  ,
  output logic                    ovf
`endif
);

  localparam int              CNT_W      = $clog2(ROWS + COLS);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROWS + COLS - 2);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(ROWS - 2);

  pe_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;

  logic w_accept;
  logic w_done;
  logic w_en;

  assign w_accept = in_valid & r_in_ready;
  assign w_done   = r_out_valid & out_ready & r_out_last;
  assign w_en     = (r_state != ST_DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FEED: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (in_last) begin
              r_state    <= ST_FLUSH;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ST_FEED;
            end
          end
        end
        ST_FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            r_state     <= ST_DRAIN;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (ROWS == 1);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_idx       <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_out_last <= (r_idx == IDX_PENULT);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Cycles without an accepted beat push zeros so a/w stay aligned in the array.
  logic [ROWS-1:0][DATA_W-1:0] w_inj_a;
  logic [COLS-1:0][DATA_W-1:0] w_inj_w;
  logic [ROWS-1:0][DATA_W-1:0] w_sk_a;
  logic [COLS-1:0][DATA_W-1:0] w_sk_w;

  assign w_inj_a = w_accept ? in_a : '0;
  assign w_inj_w = w_accept ? in_w : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    if (r == 0) begin : g_direct
      assign w_sk_a[0] = w_inj_a[0];
    end else begin : g_delay
      logic [r-1:0][DATA_W-1:0] r_sk;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_sk <= '0;
        end else if (w_done) begin
          r_sk <= '0;
        end else if (w_en) begin
          r_sk[0] <= w_inj_a[r];
          for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_sk_a[r] = r_sk[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_skew_w
    if (c == 0) begin : g_direct
      assign w_sk_w[0] = w_inj_w[0];
    end else begin : g_delay
      logic [c-1:0][DATA_W-1:0] r_sk;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_sk <= '0;
        end else if (w_done) begin
          r_sk <= '0;
        end else if (w_en) begin
          r_sk[0] <= w_inj_w[c];
          for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_sk_w[c] = r_sk[c-1];
    end
  end

  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_a_in;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] w_w_in;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  w_acc;
  logic [ROWS-1:0][DATA_W-1:0]           w_a_unused;
  logic [COLS-1:0][DATA_W-1:0]           w_w_unused;
`ifdef PE_ARR_SAT_EN
  logic [ROWS-1:0][COLS-1:0]             w_ovf_hit;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] w_a_fwd;
      logic [DATA_W-1:0] w_w_fwd;

      if (c == 0) begin : g_a_edge
        assign w_a_in[r][0] = w_sk_a[r];
      end
      if (r == 0) begin : g_w_edge
        assign w_w_in[0][c] = w_sk_w[c];
      end

      pe_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .i_en  (w_en),
        .i_clr (w_done),
        .i_a   (w_a_in[r][c]),
        .i_w   (w_w_in[r][c]),
        .o_a   (w_a_fwd),
        .o_w   (w_w_fwd),
        .o_acc (w_acc[r][c])
`ifdef PE_ARR_SAT_EN
        ,
        .o_ovf (w_ovf_hit[r][c])
`endif
      );

      if (c < COLS - 1) begin : g_a_fwd
        assign w_a_in[r][c+1] = w_a_fwd;
      end else begin : g_a_end
        assign w_a_unused[r] = w_a_fwd;
      end
      if (r < ROWS - 1) begin : g_w_fwd
        assign w_w_in[r+1][c] = w_w_fwd;
      end else begin : g_w_end
        assign w_w_unused[c] = w_w_fwd;
      end
    end
  end

`ifdef PE_ARR_SAT_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_ovf <= 1'b0;
    else if (w_done)      r_ovf <= 1'b0;
    else if (|w_ovf_hit)  r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_row_idx = r_idx;
  assign out_row     = w_acc[r_idx];
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_arr_tile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe_arr_tile : randomized self-checking bench; a 32-bit and a 16-bit     |
// |                  accumulator tile share one stimulus stream.               |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_pe_arr_tile;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AWA  = 32;
  localparam int AWB  = 16;
`ifdef PE_ARR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_last;
  logic [COLS*DW-1:0]   in_w;
  logic [ROWS*DW-1:0]   in_a;
  logic                 out_ready;

  logic                 in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [COLS*AWA-1:0]  out_row_a;
  logic [1:0]           idx_a;
  logic                 in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [COLS*AWB-1:0]  out_row_b;
  logic [1:0]           idx_b;
`ifdef PE_ARR_SAT_EN
  logic                 ovf_a, ovf_b;
`endif

  pe_arr_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AWA)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
    .in_w(in_w), .in_a(in_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_row(out_row_a), .out_row_idx(idx_a), .out_last(out_last_a), .busy(busy_a)
`ifdef PE_ARR_SAT_EN
    , .ovf(ovf_a)
`endif
  );

  pe_arr_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AWB)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
    .in_w(in_w), .in_a(in_a), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_row(out_row_b), .out_row_idx(idx_b), .out_last(out_last_b), .busy(busy_b)
`ifdef PE_ARR_SAT_EN
    , .ovf(ovf_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     a_bt [16][ROWS];
  int     w_bt [16][COLS];
  longint exp_a [ROWS][COLS];
  longint exp_b [ROWS][COLS];
  longint got_a [ROWS][COLS];
  longint got_b [ROWS][COLS];
  bit     exp_ovf_a, exp_ovf_b;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One accumulate step of a w-bit accumulator: wrap modulo 2^w or clamp.
  function automatic longint acc_step(input longint acc, input longint p, input int w,
                                      inout bit hit);
    longint s, hi, lo;
    s  = acc + p;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (SAT) begin
      if (s > hi) begin hit = 1'b1; return hi; end
      if (s < lo) begin hit = 1'b1; return lo; end
      return s;
    end
    return (s <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic build_model(input int k);
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_a[r][c] = 0;
        exp_b[r][c] = 0;
        for (int i = 0; i < k; i++) begin
          exp_a[r][c] = acc_step(exp_a[r][c], longint'(a_bt[i][r] * w_bt[i][c]), AWA, exp_ovf_a);
          exp_b[r][c] = acc_step(exp_b[r][c], longint'(a_bt[i][r] * w_bt[i][c]), AWB, exp_ovf_b);
        end
      end
  endtask

  task automatic garbage(input bit valid);
    in_valid = valid;
    in_last  = 1'($urandom);
    in_a     = $urandom;
    in_w     = $urandom;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid_a, 0);
    check({tag, "_busy"},  busy_a, 0);
    check({tag, "_ready"}, in_ready_a, 1);
    check({tag, "_idx"},   idx_a, 0);
    check({tag, "_busyb"}, busy_b, 0);
`ifdef PE_ARR_SAT_EN
    check({tag, "_ovf"},   ovf_a, 0);
    check({tag, "_ovfb"},  ovf_b, 0);
`endif
  endtask

  // gap<0 picks a random 0..2 idle cycles before each beat after the first.
  task automatic run_tile(input int k, input int gap, input int stall, input bit bp_rand,
                          input int abort_row);
    int lat, row, cyc, stall_left, g;
    bit rdy;
    build_model(k);
    for (int i = 0; i < k; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i > 0) repeat (g) begin
        garbage(1'b0);
        @(posedge clk); @(negedge clk);
      end
      check("in_ready_feed", in_ready_a, 1);
      in_valid = 1'b1;
      in_last  = (i == k - 1);
      for (int r = 0; r < ROWS; r++) in_a[r*DW +: DW] = DW'(a_bt[i][r]);
      for (int c = 0; c < COLS; c++) in_w[c*DW +: DW] = DW'(w_bt[i][c]);
      @(posedge clk); @(negedge clk);
    end
    check("in_ready_flush", in_ready_a, 0);
    check("busy_flush", busy_a, 1);
    lat = 0;
    while (!out_valid_a && lat < 40) begin
      garbage(1'b1);
      @(posedge clk); lat++; @(negedge clk);
    end
    check("latency", lat, ROWS + COLS - 1);
    check("latency_b", out_valid_b, 1);
    row = 0;
    cyc = 0;
    stall_left = stall;
    while (row < ROWS && cyc < 100) begin
      if (row == abort_row) begin
        rstn = 1'b0;
        #1;
        check_idle("abort");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        return;
      end
      if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else rdy = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      check("drain_valid", out_valid_a, 1);
      check("drain_idx", idx_a, row);
      check("drain_idx_b", idx_b, row);
      check("drain_in_ready", in_ready_a, 0);
`ifdef PE_ARR_SAT_EN
      check("ovf_a", ovf_a, exp_ovf_a);
      check("ovf_b", ovf_b, exp_ovf_b);
`endif
      if (rdy) begin
        for (int c = 0; c < COLS; c++) begin
          got_a[row][c] = longint'($signed(out_row_a[c*AWA +: AWA]));
          got_b[row][c] = longint'($signed(out_row_b[c*AWB +: AWB]));
          check($sformatf("row%0d_c%0d_a", row, c), got_a[row][c], exp_a[row][c]);
          check($sformatf("row%0d_c%0d_b", row, c), got_b[row][c], exp_b[row][c]);
        end
        check("out_last", out_last_a, (row == ROWS - 1));
      end
      out_ready = rdy;
      garbage(1'b1);
      @(posedge clk);
      if (rdy) row++;
      cyc++;
      @(negedge clk);
    end
    check("drain_rows", row, ROWS);
    if (!bp_rand) check("drain_cycles", cyc, stall + ROWS);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle("post");
  endtask

  task automatic fill(input int k, input int a_val, input int w_val);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < ROWS; r++) a_bt[i][r] = a_val;
      for (int c = 0; c < COLS; c++) w_bt[i][c] = w_val;
    end
  endtask

  initial begin
    int k;
    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_out_row_zero", out_row_a == '0, 1);
    check("rst_out_last", out_last_a, 0);
    rstn = 1'b1;
    @(negedge clk);

    fill(1, 2, 3);
    run_tile(1, 0, 0, 1'b0, -1);
    for (int r = 0; r < ROWS; r++) check("k1_val", got_a[r][r], 6);

    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < ROWS; r++) a_bt[i][r] = r + 1;
      for (int c = 0; c < COLS; c++) w_bt[i][c] = 1;
    end
    run_tile(3, 1, 0, 1'b0, -1);
    for (int r = 0; r < ROWS; r++) check("k3_bubble", got_a[r][COLS-1], 3 * (r + 1));

    fill(2, -128, -128);
    run_tile(2, 0, 5, 1'b0, -1);
    check("signed_max", got_a[1][2], 32768);

    fill(3, 127, 127);
    run_tile(3, 0, 0, 1'b0, -1);
    check("acc16_ovf", got_b[2][3], SAT ? 32767 : -17149);

    fill(2, 5, -7);
    run_tile(2, 0, 0, 1'b0, 2);

    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(1, 10);
      for (int i = 0; i < k; i++) begin
        for (int r = 0; r < ROWS; r++) a_bt[i][r] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < COLS; c++) w_bt[i][c] = int'($urandom_range(0, 255)) - 128;
      end
      run_tile(k, -1, $urandom_range(0, 3), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
